// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline forwarding selects, Mealy stall/flush control, action-class register and saturating stall/flush counters
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  idex_rs1,
  input  logic [4:0]  idex_rs2,
  input  logic [4:0]  idex_rd,
  input  logic        idex_memread,
  input  logic [4:0]  exmem_rd,
  input  logic        exmem_regwrite,
  input  logic [4:0]  memwb_rd,
  input  logic        memwb_regwrite,
  input  logic        ex_redirect,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        idex_stall,
  output logic        exmem_stall,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, LOAD_USE = 2'd2, REDIRECT = 2'd3} state_t;
  state_t state_q, state_d;
  logic pend_q, pend_d;
  logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic mw, lu;
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    return (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == rs) ? 2'b10 :
           (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == rs) ? 2'b01 : 2'b00;
  endfunction
  always_comb begin
    mw = mem_req & ~mem_ready;
    lu = idex_memread && idex_rd != 5'd0 && (idex_rd == id_rs1 || idex_rd == id_rs2) && state_q != LOAD_USE;
    state_d = !reset ? RUN : mw ? MEM_WAIT : (ex_redirect | pend_q) ? REDIRECT : lu ? LOAD_USE : RUN;
    pc_stall = state_d == MEM_WAIT || state_d == LOAD_USE;
    ifid_stall = pc_stall;
    idex_stall = state_d == MEM_WAIT;
    exmem_stall = idex_stall;
    ifid_flush = state_d == REDIRECT;
    idex_flush = state_d == REDIRECT || state_d == LOAD_USE;
    pend_d = (mw & ex_redirect) | (pend_q & (state_d != REDIRECT));
    stall_cnt_d = stall_cnt_q + {15'd0, pc_stall && stall_cnt_q != 16'hFFFF};
    flush_cnt_d = flush_cnt_q + {15'd0, ifid_flush && flush_cnt_q != 16'hFFFF};
    fwd_a = reset ? fwd_sel(idex_rs1) : 2'b00;
    fwd_b = reset ? fwd_sel(idex_rs2) : 2'b00;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      pend_q <= 1'b0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign state = state_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios plus randomized comparison against a behavioural model
module tb_pipe_hazard_ctrl;
  logic clk, reset;
  logic [4:0] id_rs1, id_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
  logic idex_memread, exmem_regwrite, memwb_regwrite, ex_redirect, mem_req, mem_ready;
  logic [1:0] fwd_a, fwd_b, state;
  logic pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush;
  logic [15:0] stall_cnt, flush_cnt;
  int checks = 0;
  int errors = 0;
  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .idex_rs1(idex_rs1),
    .idex_rs2(idex_rs2), .idex_rd(idex_rd), .idex_memread(idex_memread), .exmem_rd(exmem_rd),
    .exmem_regwrite(exmem_regwrite), .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ready(mem_ready), .fwd_a(fwd_a),
    .fwd_b(fwd_b), .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
    .exmem_stall(exmem_stall), .ifid_flush(ifid_flush), .idex_flush(idex_flush), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  wire [5:0] ctl = {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush};
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    {id_rs1, id_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd} = '0;
    {idex_memread, exmem_regwrite, memwb_regwrite, ex_redirect, mem_req, mem_ready} = '0;
  endtask
  task automatic do_reset();
    reset = 0;
    idle();
    tick();
    reset = 1;
  endtask
  task automatic test_reset();
    reset = 0;
    idex_rs1 = 3; idex_rs2 = 4; exmem_rd = 3; exmem_regwrite = 1; memwb_rd = 4; memwb_regwrite = 1;
    mem_req = 1; ex_redirect = 1; idex_memread = 1; idex_rd = 2; id_rs1 = 2;
    #1;
    checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL reset_ctl got %b exp 000000", ctl); end
    checks++; if ({fwd_a, fwd_b} !== 4'b0) begin errors++; $display("FAIL reset_fwd got %b/%b exp 00/00", fwd_a, fwd_b); end
    tick();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
    reset = 1;
    idle();
    #1;
    checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL reset_release_ctl got %b exp 000000", ctl); end
    tick();
  endtask
  task automatic test_forwarding();
    idle();
    idex_rs1 = 5; idex_rs2 = 5; exmem_rd = 5; exmem_regwrite = 1; memwb_rd = 5; memwb_regwrite = 1;
    #1;
    checks++; if (fwd_a !== 2'b10) begin errors++; $display("FAIL fwd_exmem got %b exp 10", fwd_a); end
    checks++; if (fwd_b !== 2'b10) begin errors++; $display("FAIL fwd_b_exmem got %b exp 10", fwd_b); end
    exmem_rd = 0;
    #1;
    checks++; if (fwd_a !== 2'b01) begin errors++; $display("FAIL fwd_memwb got %b exp 01", fwd_a); end
    exmem_rd = 5; exmem_regwrite = 0; idex_rs2 = 9;
    #1;
    checks++; if (fwd_a !== 2'b01 || fwd_b !== 2'b00) begin errors++; $display("FAIL fwd_nowrite got %b/%b exp 01/00", fwd_a, fwd_b); end
    memwb_rd = 0; memwb_regwrite = 1; idex_rs1 = 0;
    #1;
    checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL fwd_zero got %b exp 00", fwd_a); end
    idle();
  endtask
  task automatic test_load_use();
    do_reset();
    idex_memread = 1; idex_rd = 0; id_rs1 = 0; id_rs2 = 0;
    #1;
    checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL lu_r0 got %b exp 000000", ctl); end
    idex_rd = 7; id_rs2 = 7;
    #1;
    checks++; if (ctl !== 6'b110001) begin errors++; $display("FAIL lu_cycle1 got %b exp 110001", ctl); end
    tick();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL lu_state got %0d exp 2", state); end
    checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL lu_cycle2 got %b exp 000000", ctl); end
    tick();
    idle();
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt got %0d exp 1", stall_cnt); end
  endtask
  task automatic test_deferred_redirect();
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int c = 1; c <= 3; c++) begin
      ex_redirect = (c == 2);
      #1;
      checks++; if (ctl !== 6'b111100) begin errors++; $display("FAIL defer_wait c=%0d got %b exp 111100", c, ctl); end
      tick();
    end
    ex_redirect = 0; mem_ready = 1;
    #1;
    checks++; if (ctl !== 6'b000011) begin errors++; $display("FAIL defer_flush got %b exp 000011", ctl); end
    tick();
    mem_req = 0; mem_ready = 0;
    #1;
    checks++; if (ctl !== 6'b0 || state !== 2'd3) begin errors++; $display("FAIL defer_after got %b st %0d exp 000000 st 3", ctl, state); end
    tick();
    checks++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd3) begin errors++; $display("FAIL defer_cnt got %0d/%0d exp 1/3", flush_cnt, stall_cnt); end
  endtask
  task automatic test_simultaneous();
    do_reset();
    ex_redirect = 1; idex_memread = 1; idex_rd = 6; id_rs1 = 6;
    #1;
    checks++; if (ctl !== 6'b000011) begin errors++; $display("FAIL simul_ctl got %b exp 000011", ctl); end
    tick();
    idle();
    #1;
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL simul_state got %0d exp 3", state); end
    tick();
  endtask
  task automatic test_reset_mid_wait();
    do_reset();
    mem_req = 1; mem_ready = 0; ex_redirect = 1;
    tick();
    ex_redirect = 0;
    tick();
    reset = 0;
    #1;
    checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL rmw_in_reset got %b exp 000000", ctl); end
    tick();
    reset = 1; mem_ready = 1;
    #1;
    checks++; if (state !== 2'd0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL rmw_cleared got st %0d cnt %0d/%0d exp 0 0/0", state, stall_cnt, flush_cnt); end
    checks++; if (ctl !== 6'b0) begin errors++; $display("FAIL rmw_no_flush got %b exp 000000", ctl); end
    tick();
    idle();
    #1;
    checks++; if (flush_cnt !== 16'd0) begin errors++; $display("FAIL rmw_flush_cnt got %0d exp 0", flush_cnt); end
  endtask
  task automatic test_random();
    logic [5:0] ctl_tab [4] = '{6'b000000, 6'b111100, 6'b110001, 6'b000011};
    int m_state, m_sc, m_fc, act;
    bit m_pend, mwv, luv;
    logic [5:0] ectl;
    logic [1:0] efa, efb;
    do_reset();
    m_state = 0; m_pend = 0; m_sc = 0; m_fc = 0;
    for (int n = 0; n < 3000; n++) begin
      reset = $urandom_range(0, 39) != 0;
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      idex_rs1 = 5'($urandom_range(0, 3)); idex_rs2 = 5'($urandom_range(0, 3));
      idex_rd = 5'($urandom_range(0, 3)); exmem_rd = 5'($urandom_range(0, 3)); memwb_rd = 5'($urandom_range(0, 3));
      idex_memread = 1'($urandom); exmem_regwrite = 1'($urandom); memwb_regwrite = 1'($urandom);
      ex_redirect = $urandom_range(0, 5) == 0; mem_req = $urandom_range(0, 2) == 0; mem_ready = 1'($urandom);
      #1;
      mwv = mem_req && !mem_ready;
      luv = idex_memread && idex_rd != 0 && (idex_rd == id_rs1 || idex_rd == id_rs2) && m_state != 2;
      act = !reset ? 0 : mwv ? 1 : (ex_redirect || m_pend) ? 3 : luv ? 2 : 0;
      ectl = ctl_tab[act];
      efa = !reset ? 2'd0 : (exmem_regwrite && exmem_rd != 0 && exmem_rd == idex_rs1) ? 2'd2 : (memwb_regwrite && memwb_rd != 0 && memwb_rd == idex_rs1) ? 2'd1 : 2'd0;
      efb = !reset ? 2'd0 : (exmem_regwrite && exmem_rd != 0 && exmem_rd == idex_rs2) ? 2'd2 : (memwb_regwrite && memwb_rd != 0 && memwb_rd == idex_rs2) ? 2'd1 : 2'd0;
      checks++; if (fwd_a !== efa || fwd_b !== efb) begin errors++; $display("FAIL rnd_fwd n=%0d got %b/%b exp %b/%b", n, fwd_a, fwd_b, efa, efb); end
      checks++; if (ctl !== ectl) begin errors++; $display("FAIL rnd_ctl n=%0d got %b exp %b", n, ctl, ectl); end
      checks++; if (state !== 2'(m_state)) begin errors++; $display("FAIL rnd_state n=%0d got %0d exp %0d", n, state, m_state); end
      checks++; if (stall_cnt !== 16'(m_sc) || flush_cnt !== 16'(m_fc)) begin errors++; $display("FAIL rnd_cnt n=%0d got %0d/%0d exp %0d/%0d", n, stall_cnt, flush_cnt, m_sc, m_fc); end
      tick();
      if (!reset) begin
        m_state = 0; m_pend = 0; m_sc = 0; m_fc = 0;
      end else begin
        m_pend = (mwv && ex_redirect) ? 1'b1 : (act == 3) ? 1'b0 : m_pend;
        m_state = act;
        if (ectl[5] && m_sc < 65535) m_sc++;
        if (ectl[1] && m_fc < 65535) m_fc++;
      end
    end
    reset = 1;
    idle();
  endtask
  task automatic test_saturation();
    do_reset();
    mem_req = 1; mem_ready = 0;
    repeat (65534) tick();
    checks++; if (stall_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got %h exp fffe", stall_cnt); end
    repeat (6) tick();
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h exp ffff", stall_cnt); end
    idle();
  endtask
  initial begin
    clk = 0;
    reset = 0;
    idle();
    test_reset();
    test_forwarding();
    test_load_use();
    test_deferred_redirect();
    test_simultaneous();
    test_reset_mid_wait();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: `clk` and `reset`.
REQ-002 Ports SHALL be as follows, one per line, as name, direction, width, meaning:
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-low reset.
- `id_rs1`, `id_rs2` in 5 each: source registers decoded from the IF/ID instruction.
- `idex_rs1`, `idex_rs2`, `idex_rd` in 5 each: ID/EX register fields.
- `idex_memread` in 1: ID/EX MemRead.
- `exmem_rd` in 5, `exmem_regwrite` in 1: EX/MEM destination register and RegWrite.
- `memwb_rd` in 5, `memwb_regwrite` in 1: MEM/WB destination register and RegWrite.
- `ex_redirect` in 1: branch taken or jump resolved in EX this cycle.
- `mem_req` in 1: data memory access active in MEM.
- `mem_ready` in 1: data memory completes the access this cycle.
- `fwd_a`, `fwd_b` out 2 each: ALU operand source select.
  - 00: register file.
  - 01: MEM/WB.
  - 10: EX/MEM.
- `pc_stall`, `ifid_stall`, `idex_stall`, `exmem_stall` out 1 each: hold the PC or the named pipeline register.
- `ifid_flush`, `idex_flush` out 1 each: load a bubble (all zeros) into the named register.
- `state` out 2: registered action class.
  - 0: RUN.
  - 1: MEM_WAIT.
  - 2: LOAD_USE.
  - 3: REDIRECT.
- `stall_cnt` out 16: saturating count of cycles with `pc_stall` = 1.
- `flush_cnt` out 16: saturating count of cycles with `ifid_flush` = 1.

Function
REQ-003 `fwd_a` SHALL be combinational:
- 10 if `exmem_regwrite` = 1, `exmem_rd` != 0 and `exmem_rd` == `idex_rs1`.
- Else 01 if `memwb_regwrite` = 1, `memwb_rd` != 0 and `memwb_rd` == `idex_rs1`.
- Else 00.
REQ-004 `fwd_b` SHALL follow the same rule as REQ-003 using `idex_rs2`; EX/MEM SHALL always take priority over MEM/WB.
REQ-005 The load-use condition `lu` SHALL be true when all of the following hold:
- `idex_memread` = 1.
- `idex_rd` != 0.
- `idex_rd` equals `id_rs1` or `id_rs2`.
- `state` != LOAD_USE (this guard bounds a load-use stall to exactly one cycle).
REQ-006 The memory-wait condition `mw` SHALL be `mem_req` = 1 and `mem_ready` = 0.
REQ-007 An internal flag `pend` SHALL be set when `ex_redirect` = 1 in a cycle where `mw` = 1; it SHALL be cleared in the cycle the deferred flush is issued.
REQ-008 Action priority SHALL be MEM_WAIT, then REDIRECT, then LOAD_USE, then RUN, evaluated each cycle.
REQ-009 MEM_WAIT action (`mw` = 1):
- `pc_stall`, `ifid_stall`, `idex_stall` and `exmem_stall` SHALL be 1.
- Both flush outputs SHALL be 0.
REQ-010 REDIRECT action (`mw` = 0 and (`ex_redirect` = 1 or `pend` = 1)):
- `ifid_flush` and `idex_flush` SHALL be 1.
- All stall outputs SHALL be 0.
- `lu` SHALL be ignored.
REQ-011 LOAD_USE action (`mw` = 0, no redirect, `lu` = 1):
- `pc_stall`, `ifid_stall` and `idex_flush` SHALL be 1.
- All other stall and flush outputs SHALL be 0.
REQ-012 RUN action: all stall and flush outputs SHALL be 0.
REQ-013 Stall and flush outputs SHALL be combinational (Mealy) from inputs, `state` and `pend`, so they act in the same cycle as the condition.
REQ-014 On each rising edge, `state` SHALL take the code of the action taken in that cycle; `state` therefore reflects the previous cycle's action.
REQ-015 `stall_cnt` SHALL increment by 1 on each edge where `pc_stall` = 1, and SHALL hold at 16'hFFFF with no wrap.
REQ-016 `flush_cnt` SHALL increment by 1 on each edge where `ifid_flush` = 1, saturating at 16'hFFFF.
REQ-017 A redirect with `pend` already set SHALL produce exactly one flush cycle, not two.
REQ-018 If `mem_ready` = 1 while `mem_req` = 1, the cycle SHALL NOT be treated as MEM_WAIT.
REQ-019 Fields with register index 0 SHALL never cause forwarding or a stall.

Reset
REQ-020 While `reset` = 0 at a rising edge, the following SHALL be set to their reset values:
- `state` = RUN (0).
- `pend` = 0.
- `stall_cnt` = 0.
- `flush_cnt` = 0.
REQ-021 While `reset` = 0, all stall and flush outputs SHALL be 0, and `fwd_a` = `fwd_b` = 00, regardless of the other inputs.
REQ-022 A reset asserted during MEM_WAIT with `pend` = 1 SHALL discard the pending redirect; no flush SHALL occur after `reset` returns to 1.

Verification
REQ-023 Forwarding:
- Stimulus: `idex_rs1` = 5, `exmem_rd` = 5 with RegWrite = 1, `memwb_rd` = 5 with RegWrite = 1.
- Required response: `fwd_a` = 10.
- Stimulus: `exmem_rd` = 0.
- Required response: `fwd_a` = 01.
REQ-024 Load-use:
- Stimulus: `idex_memread` = 1, `idex_rd` = 7, `id_rs2` = 7 held for 2 cycles.
- Required response, cycle 1: `pc_stall` = 1, `ifid_stall` = 1, `idex_flush` = 1.
- Required response, cycle 2 (`state` = 2): no stall.
- Required response overall: `stall_cnt` = 1.
REQ-025 Deferred redirect:
- Stimulus: `mem_req` = 1, `mem_ready` = 0 for 3 cycles with `ex_redirect` pulsed in cycle 2, then `mem_ready` = 1.
- Required response: 3 cycles of all stalls, then exactly 1 cycle of `ifid_flush` = `idex_flush` = 1.
- Required response overall: `flush_cnt` = 1.
REQ-026 Simultaneous events:
- Stimulus: `ex_redirect` = 1 and `lu` true, with `mw` = 0.
- Required response: flushes only, `pc_stall` = 0, `state` = 3 on the next cycle.
REQ-027 Saturation:
- Stimulus: hold `mw` = 1 for 65,540 cycles.
- Required response: `stall_cnt` = 16'hFFFF.
REQ-028 Reset mid-wait:
- Stimulus: `reset` = 0 for 1 cycle while `pend` = 1.
- Required response: `state` = 0, counters = 0, no flush after release.
